// File: rtl/shift_pipe_pkg.sv
// shift_pipe_pkg: shared definitions for the shift_pipe delay line.
//   DEF_WIDTH / DEF_DEPTH : default data width and stage count
//   stage_t               : one stage's contents (valid + data) at the default width
//   occ_width()           : bit width of the occupancy count for a given depth
package shift_pipe_pkg;

  localparam int DEF_WIDTH = 32'sd8;
  localparam int DEF_DEPTH = 32'sd4;

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
  } stage_t;

  // Occupancy must represent 0..depth inclusive, hence depth+1 codes.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// shift_pipe_stage: one register stage of the shift_pipe delay line.
// Ports:
//   clk      : clock, all updates on posedge
//   rst      : synchronous active-high reset, clears data and valid
//   flush    : clears valid only, data is kept
//   en       : load in_data/in_valid; otherwise hold
//   in_data  : data from the neighbouring stage (or din)
//   in_valid : valid from the neighbouring stage (or din_valid)
//   data     : registered stage data
//   valid    : registered stage valid
module shift_pipe_stage
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // Stage register: rst > flush > en > hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= {WIDTH{1'b0}};
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (en) begin
      data  <= in_data;
      valid <= in_valid;
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// shift_pipe: WIDTH-bit, DEPTH-stage delay line with per-stage valid bits,
// stall (en=0), flush (drop valids, keep data) and a runtime tap.
// Optional feature macro: SHIFT_PIPE_BIDIR_EN adds a dir input; dir=1 shifts
// from stage DEPTH-1 toward stage 0 with din entering at stage DEPTH-1.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   en                : shift enable (0 = hold every stage)
//   din, din_valid    : sample entering the line
//   flush             : clear all valid bits without touching data
//   tap_sel           : stage index shown on tap_out/tap_valid
//   dir               : (SHIFT_PIPE_BIDIR_EN only) 0 forward, 1 reverse
//   dout, dout_valid  : stage DEPTH-1 contents
//   tap_out, tap_valid: stage tap_sel contents, zero when tap_sel >= DEPTH
//   occupancy         : number of valid stages (0..DEPTH)
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int TAPW  = $clog2(DEPTH),
  localparam int OCCW  = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             flush,
  input  logic [TAPW-1:0]  tap_sel,
`ifdef SHIFT_PIPE_BIDIR_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic [WIDTH-1:0] tap_out,
  output logic             tap_valid,
  output logic [OCCW-1:0]  occupancy
);

  logic [WIDTH-1:0] data_r [DEPTH];
  logic [DEPTH-1:0] valid_r;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] fwd_data_s;
    logic             fwd_valid_s;
    logic [WIDTH-1:0] in_data_s;
    logic             in_valid_s;

    // Forward source: din feeds stage 0, every other stage takes its predecessor.
    if (i == 0) begin : g_fwd_head
      assign fwd_data_s  = din;
      assign fwd_valid_s = din_valid;
    end else begin : g_fwd_body
      assign fwd_data_s  = data_r[i-1];
      assign fwd_valid_s = valid_r[i-1];
    end

`ifdef SHIFT_PIPE_BIDIR_EN
    logic [WIDTH-1:0] rev_data_s;
    logic             rev_valid_s;

    // Reverse source: din feeds the last stage, every other stage takes its successor.
    if (i == DEPTH - 1) begin : g_rev_head
      assign rev_data_s  = din;
      assign rev_valid_s = din_valid;
    end else begin : g_rev_body
      assign rev_data_s  = data_r[i+1];
      assign rev_valid_s = valid_r[i+1];
    end

    // Direction mux for this stage's load value.
    always_comb begin
      in_data_s  = fwd_data_s;
      in_valid_s = fwd_valid_s;
      if (dir) begin
        in_data_s  = rev_data_s;
        in_valid_s = rev_valid_s;
      end else begin
        in_data_s  = fwd_data_s;
        in_valid_s = fwd_valid_s;
      end
    end
`else
    assign in_data_s  = fwd_data_s;
    assign in_valid_s = fwd_valid_s;
`endif

    shift_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .en       (en),
      .in_data  (in_data_s),
      .in_valid (in_valid_s),
      .data     (data_r[i]),
      .valid    (valid_r[i])
    );
  end

  assign dout       = data_r[DEPTH-1];
  assign dout_valid = valid_r[DEPTH-1];

  // Tap mux; indices past the last stage read as an empty stage.
  always_comb begin
    tap_out   = {WIDTH{1'b0}};
    tap_valid = 1'b0;
    if (int'(tap_sel) < DEPTH) begin
      tap_out   = data_r[tap_sel];
      tap_valid = valid_r[tap_sel];
    end else begin
      tap_out   = {WIDTH{1'b0}};
      tap_valid = 1'b0;
    end
  end

  // Popcount of the stage valid bits.
  always_comb begin
    occupancy = {OCCW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + {{(OCCW-1){1'b0}}, valid_r[i]};
    end
  end

endmodule
